dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the `dmemory` data memory. It shares the single memory port between the core load/store unit (port 0) and a secondary master such as DMA or debug (port 1), using round-robin grant. It maps RISC-V load/store `func3` codes onto the memory's byte-lane encoding and sign- or zero-extends load data. It returns each result with a one-cycle valid pulse.

## Interface
- `RESET_LAST`, default 1: value of the last-grant register after reset. The default of 1 gives port 0 first priority.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` input 1: access request. Hold high, with fields stable, until `pN_ack`.
- `p0_we`, `p1_we` input 1: 1 = store, 0 = load.
- `p0_func3`, `p1_func3` input 3: RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `p0_addr`, `p1_addr` input 32: address, forwarded unchanged to memory.
- `p0_wdata`, `p1_wdata` input 32: store data, right-aligned.
- `p0_ack`, `p1_ack` output 1: one-cycle pulse; the request has been accepted.
- `p0_rvalid`, `p1_rvalid` output 1: one-cycle pulse; the access is complete.
- `p0_rdata`, `p1_rdata` output 32: extended load data, valid with `rvalid`. It is 0 for stores and errors.
- `p0_err`, `p1_err` output 1: valid with `rvalid`; 1 means illegal `func3`.
- `mem_addr` output 32: to `dmemory.addr`.
- `mem_wdata` output 32: to `dmemory.wdata`.
- `mem_func3` output 3: to `dmemory.func3`. Only 000, 001 or 010 is ever driven.
- `mem_dmwen` output 1: to `dmemory.dmwen`.
- `mem_rdata` input 32: from `dmemory.dmout`.

## Operation
- FSM states are IDLE, ISSUE and WAIT. Reset state is IDLE.
- **IDLE / WAIT:**
  - If any `req` is high at the clock edge, grant one port, latch its fields into the `mem_*` registers and go to ISSUE.
  - Otherwise, WAIT returns to IDLE.
  - IDLE holds the `mem_*` registers, with `mem_dmwen` low.
- **Arbitration:**
  - A single requester wins.
  - If both are requesting, the port that was not granted last wins.
  - The last-grant register updates on every grant.
- **Grant edge actions:**
  - `pN_ack` is registered high for exactly the ISSUE cycle.
  - `mem_func3` = {0, func3[1:0]}.
  - `mem_dmwen` = `we` for legal codes, and only for the ISSUE cycle.
- **ISSUE → WAIT:**
  - The memory performs the access at the ISSUE→WAIT edge.
  - `mem_rdata` is valid during WAIT.
- **WAIT edge (completion):**
  - Register `pN_rvalid`, `pN_rdata` and `pN_err` for the owning port.
  - A new grant may occur at this same edge.
- **Load extension:**
  - B: sign-extend bit 7.
  - H: sign-extend bit 15.
  - BU/HU: zero-extend.
  - W: pass through.
  - `func3[2]` selects zero-extension.
- **Illegal func3 (011, 110, 111):**
  - The port is still granted and acked.
  - `mem_func3` is forced to 010 and `mem_dmwen` is held 0.
  - The response gives `err`=1 and `rdata`=0.
- **Stores:** `rvalid` pulses with `rdata`=0 and `err`=0.
- **Request withdrawal:** a requester dropping `req` before `ack` is not supported. If the request was not yet granted, it is simply not serviced.
- **Asynchronous reset:**
  - All outputs go to 0 immediately, including `mem_dmwen`.
  - State returns to IDLE and the last-grant register is set to `RESET_LAST`.
  - An in-flight access is dropped and no `rvalid` is produced.
  - A store whose ISSUE edge had not yet occurred is not written.

## Timing
- Reset values: `ack`, `rvalid`, `err` and `mem_dmwen` are 0. `rdata`, `mem_addr`, `mem_wdata` and `mem_func3` are 0.
- For a request sampled at edge T:
  - `ack` is high in T..T+1.
  - The memory access happens at edge T+1.
  - `rvalid` is high in T+2..T+3.
- Back-to-back throughput is one access per 2 cycles.
- With both ports continuously requesting, grants alternate 0,1,0,1… Each port waits at most one other access.
- All outputs are registered; there are no combinational paths from `req` to any output.

## Test plan
- **Word read:** memory word at 0x10 = 0xDEADBEEF; port 0 LW 0x10 → `ack` at T+1, `rvalid` at T+3, `rdata`=0xDEADBEEF, `err`=0.
- **Sign and zero extension:** low byte 0x80 → LB gives 0xFFFFFF80 and LBU gives 0x00000080. Low half 0x8001 → LH gives 0xFFFF8001 and LHU gives 0x00008001.
- **Store then read back:** SH of 0x1234ABCD at 0x20 (word previously 0) → `mem_dmwen` high for exactly 1 cycle. A later LW 0x20 returns 0x0000ABCD.
- **Contention:** both ports request continuously for 4 accesses each → grant order 0,1,0,1,0,1,0,1, with each `rvalid` on the correct port only.
- **Illegal code:** `func3`=011 store to 0x30 → `ack`, then `rvalid` with `err`=1 and `rdata`=0. `mem_dmwen` never rises and memory is unchanged.
- **Reset mid-operation:** assert `rst_n`=0 during the WAIT of a port-1 load → all outputs 0 at once and no `rvalid`. After release, simultaneous requests grant port 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for the dmemory data memory.
// Grants one port at a time, drives the memory for one ISSUE cycle, then
// returns sign/zero-extended load data with a one-cycle rvalid pulse.
//
// Handshake: a port raises pN_req with its fields stable and holds them until
// it sees pN_ack (a one-cycle pulse in the ISSUE cycle); it must then drop req
// before the following edge unless it has a new access ready. The result comes
// back two cycles after ack as a one-cycle pN_rvalid with pN_rdata/pN_err.
module dmem_arbiter #(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [2:0]  p0_func3,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [2:0]  p1_func3,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  output logic        mem_dmwen,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        own_we_q, own_we_d;
  logic [2:0]  own_f3_q, own_f3_d;
  logic        own_err_q, own_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_func3_q, mem_func3_d;
  logic        mem_dmwen_q, mem_dmwen_d;
  logic        p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic        p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;

  logic        grant;
  logic        grant_sel;
  logic        sel_we;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_illegal;
  logic [31:0] load_ext;
  logic [31:0] resp;

  // Pick the winner (sole requester, else the port not granted last) and mux its fields.
  always_comb begin
    grant_sel   = (p0_req && p1_req) ? ~last_q : p1_req;
    sel_we      = grant_sel ? p1_we    : p0_we;
    sel_f3      = grant_sel ? p1_func3 : p0_func3;
    sel_addr    = grant_sel ? p1_addr  : p0_addr;
    sel_wdata   = grant_sel ? p1_wdata : p0_wdata;
    sel_illegal = (sel_f3 == 3'b011) || (sel_f3[2:1] == 2'b11);
  end

  // Extend the memory word according to the owner's width; func3[2] selects zero-extension.
  always_comb begin
    case (own_f3_q[1:0])
      2'b00:   load_ext = {{24{mem_rdata[7]  & ~own_f3_q[2]}}, mem_rdata[7:0]};
      2'b01:   load_ext = {{16{mem_rdata[15] & ~own_f3_q[2]}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
    resp = (own_err_q || own_we_q) ? 32'd0 : load_ext;
  end

  // Next state, grant bookkeeping and registered-output values.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    own_we_d    = own_we_q;
    own_f3_d    = own_f3_q;
    own_err_d   = own_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_func3_d = mem_func3_q;
    mem_dmwen_d = 1'b0;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_err_d    = p0_err_q;
    p1_err_d    = p1_err_q;
    grant       = 1'b0;
    case (state_q)
      IDLE:  grant = p0_req | p1_req;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (owner_q) begin
          p1_rvalid_d = 1'b1;
          p1_rdata_d  = resp;
          p1_err_d    = own_err_q;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_rdata_d  = resp;
          p0_err_d    = own_err_q;
        end
        grant   = p0_req | p1_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d     = ISSUE;
      last_d      = grant_sel;
      owner_d     = grant_sel;
      own_we_d    = sel_we;
      own_f3_d    = sel_f3;
      own_err_d   = sel_illegal;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_func3_d = sel_illegal ? 3'b010 : {1'b0, sel_f3[1:0]};
      mem_dmwen_d = sel_we & ~sel_illegal;
      p0_ack_d    = ~grant_sel;
      p1_ack_d    = grant_sel;
    end
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= RESET_LAST;
      owner_q     <= 1'b0;
      own_we_q    <= 1'b0;
      own_f3_q    <= 3'b000;
      own_err_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_func3_q <= 3'b000;
      mem_dmwen_q <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= 32'd0;
      p1_rdata_q  <= 32'd0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      own_we_q    <= own_we_d;
      own_f3_q    <= own_f3_d;
      own_err_q   <= own_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_func3_q <= mem_func3_d;
      mem_dmwen_q <= mem_dmwen_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_func3 = mem_func3_q;
  assign mem_dmwen = mem_dmwen_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small byte memory
// standing in for dmemory and a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [2:0]  p0_func3 = 0, p1_func3 = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_rvalid, p0_err, p1_ack, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [2:0]  mem_func3;
  logic        mem_dmwen;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_count = 0;
  int grant_log[$];

  // clock / reset
  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_func3(p0_func3), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_func3(p1_func3), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_dmwen(mem_dmwen), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // dmemory stand-in: 256 bytes, word read registered each edge, byte-lane write
  logic [7:0] dm [256];
  logic [7:0] dm_a;
  initial forever begin
    @(posedge clk);
    dm_a = mem_addr[7:0];
    mem_rdata <= {dm[dm_a + 8'd3], dm[dm_a + 8'd2], dm[dm_a + 8'd1], dm[dm_a]};
    if (mem_dmwen) begin
      dm[dm_a] = mem_wdata[7:0];
      if (mem_func3 != 3'b000) dm[dm_a + 8'd1] = mem_wdata[15:8];
      if (mem_func3 == 3'b010) begin
        dm[dm_a + 8'd2] = mem_wdata[23:16];
        dm[dm_a + 8'd3] = mem_wdata[31:24];
      end
    end
  end

  // reference model: one access per two cycles, round-robin, results from a reference memory
  logic [7:0]  ref_m [256];
  bit          exp_ack [2][N];
  bit          exp_rv  [2][N];
  bit          exp_wen [N];
  logic [2:0]  exp_f3  [N];
  logic [31:0] exp_addr[N];
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          last_g = 1;
  int          next_grant = 0;
  int          mw, nb;
  logic        mwe, mill;
  logic [2:0]  mf;
  logic [31:0] ma, mwd, mword, mv;
  logic [32:0] mresp;
  logic [7:0]  midx;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst_n && cyc + 2 < N && cyc >= next_grant && (p0_req || p1_req)) begin
      if (p0_req && p1_req) mw = (last_g == 0) ? 1 : 0;
      else mw = p0_req ? 0 : 1;
      last_g = mw;
      mwe  = (mw == 1) ? p1_we    : p0_we;
      mf   = (mw == 1) ? p1_func3 : p0_func3;
      ma   = (mw == 1) ? p1_addr  : p0_addr;
      mwd  = (mw == 1) ? p1_wdata : p0_wdata;
      mill = (mf == 3'd3) || (mf == 3'd6) || (mf == 3'd7);
      exp_ack[mw][cyc] = 1'b1;
      exp_wen[cyc]     = mwe && !mill;
      exp_f3[cyc]      = mill ? 3'd2 : (mf % 3'd4);
      exp_addr[cyc]    = ma;
      nb = 1 << (mf % 4);
      if (mill) begin
        mresp = {1'b1, 32'd0};
      end else if (mwe) begin
        for (int i = 0; i < nb; i++) begin
          midx = ma[7:0] + 8'(i);
          ref_m[midx] = 8'(mwd >> (8 * i));
        end
        mresp = 33'd0;
      end else begin
        mword = 32'd0;
        for (int i = 0; i < 4; i++) begin
          midx = ma[7:0] + 8'(i);
          mword = mword | ({24'd0, ref_m[midx]} << (8 * i));
        end
        if (mf % 4 == 0) begin
          mv = mword % 256;
          if (mf == 3'd0 && mv >= 128) mv = mv - 32'd256;
        end else if (mf % 4 == 1) begin
          mv = mword % 65536;
          if (mf == 3'd1 && mv >= 32768) mv = mv - 32'd65536;
        end else begin
          mv = mword;
        end
        mresp = {1'b0, mv};
      end
      exp_rv[mw][cyc + 2] = 1'b1;
      if (mw == 0) exp_q0.push_back(mresp);
      else exp_q1.push_back(mresp);
      next_grant = cyc + 2;
    end
  end

  // reset drops everything in flight
  initial forever begin
    @(negedge rst_n);
    for (int i = 0; i < N; i++) begin
      if (i >= cyc) begin
        exp_ack[0][i] = 1'b0;
        exp_ack[1][i] = 1'b0;
        exp_rv[0][i]  = 1'b0;
        exp_rv[1][i]  = 1'b0;
        exp_wen[i]    = 1'b0;
      end
    end
    exp_q0.delete();
    exp_q1.delete();
    last_g = 1;
    next_grant = 0;
  end

  // compare process: every out-of-reset cycle
  initial forever begin
    @(negedge clk);
    if (rst_n && cyc > 0 && cyc < N) begin
      chk("p0_ack", 64'(p0_ack), 64'(exp_ack[0][cyc]));
      chk("p1_ack", 64'(p1_ack), 64'(exp_ack[1][cyc]));
      chk("p0_rvalid", 64'(p0_rvalid), 64'(exp_rv[0][cyc]));
      chk("p1_rvalid", 64'(p1_rvalid), 64'(exp_rv[1][cyc]));
      chk("mem_dmwen", 64'(mem_dmwen), 64'(exp_wen[cyc]));
      if (exp_ack[0][cyc] || exp_ack[1][cyc]) begin
        chk("mem_func3", 64'(mem_func3), 64'(exp_f3[cyc]));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr[cyc]));
      end
      if (p0_rvalid) begin
        if (exp_q0.size() == 0) chk("p0_resp_unexpected", 64'(1), 64'(0));
        else chk("p0_resp", 64'({p0_err, p0_rdata}), 64'(exp_q0.pop_front()));
      end
      if (p1_rvalid) begin
        if (exp_q1.size() == 0) chk("p1_resp_unexpected", 64'(1), 64'(0));
        else chk("p1_resp", 64'({p1_err, p1_rdata}), 64'(exp_q1.pop_front()));
      end
      if (p0_ack) grant_log.push_back(0);
      if (p1_ack) grant_log.push_back(1);
      if (mem_dmwen) wen_count++;
    end
  end

  // driver tasks
  task automatic drive(input int p, input logic r, input logic we, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      p0_req = r; p0_we = we; p0_func3 = f; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = r; p1_we = we; p1_func3 = f; p1_addr = a; p1_wdata = wd;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, output int lat);
    logic got;
    drive(p, 1'b1, we, f, a, wd);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = (p == 0) ? p0_ack : p1_ack;
    end
    if (!got) chk("ack_timeout", 64'(0), 64'(1));
    drive(p, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic wait_rv(input int p, output logic [31:0] rd, output logic er, output int lat);
    logic got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = (p == 0) ? p0_rvalid : p1_rvalid;
    end
    if (!got) chk("rvalid_timeout", 64'(0), 64'(1));
    rd = (p == 0) ? p0_rdata : p1_rdata;
    er = (p == 0) ? p0_err : p1_err;
  endtask

  task automatic access(input int p, input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int al, rl;
    issue(p, we, f, a, wd, al);
    chk("ack_latency", 64'(al), 64'(1));
    wait_rv(p, rd, er, rl);
    chk("rvalid_latency", 64'(rl), 64'(2));
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dm[a + 8'(i)]    = 8'(w >> (8 * i));
      ref_m[a + 8'(i)] = 8'(w >> (8 * i));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_p0_ack"}, 64'(p0_ack), 64'(0));
    chk({tag, "_p1_ack"}, 64'(p1_ack), 64'(0));
    chk({tag, "_p0_rvalid"}, 64'(p0_rvalid), 64'(0));
    chk({tag, "_p1_rvalid"}, 64'(p1_rvalid), 64'(0));
    chk({tag, "_p0_rdata"}, 64'(p0_rdata), 64'(0));
    chk({tag, "_p1_rdata"}, 64'(p1_rdata), 64'(0));
    chk({tag, "_p0_err"}, 64'(p0_err), 64'(0));
    chk({tag, "_p1_err"}, 64'(p1_err), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_mem_func3"}, 64'(mem_func3), 64'(0));
    chk({tag, "_mem_dmwen"}, 64'(mem_dmwen), 64'(0));
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // directed stimulus
  logic [31:0] rd;
  logic        er;
  initial begin
    for (int i = 0; i < 256; i += 4) poke(8'(i), 32'd0);
    poke(8'h10, 32'hDEADBEEF);
    poke(8'h30, 32'hCAFEF00D);
    poke(8'h40, 32'h11223380);
    poke(8'h44, 32'h55668001);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // word read
    access(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er);
    chk("lw_10_rdata", 64'(rd), 64'h00000000DEADBEEF);
    chk("lw_10_err", 64'(er), 64'(0));

    // sign and zero extension
    access(1, 1'b0, 3'b000, 32'h40, 32'd0, rd, er);
    chk("lb_40", 64'(rd), 64'h00000000FFFFFF80);
    access(0, 1'b0, 3'b100, 32'h40, 32'd0, rd, er);
    chk("lbu_40", 64'(rd), 64'h0000000000000080);
    access(1, 1'b0, 3'b001, 32'h44, 32'd0, rd, er);
    chk("lh_44", 64'(rd), 64'h00000000FFFF8001);
    access(0, 1'b0, 3'b101, 32'h44, 32'd0, rd, er);
    chk("lhu_44", 64'(rd), 64'h0000000000008001);

    // store then read back
    wen_count = 0;
    access(0, 1'b1, 3'b001, 32'h20, 32'h1234ABCD, rd, er);
    chk("sh_rdata", 64'(rd), 64'(0));
    chk("sh_err", 64'(er), 64'(0));
    chk("sh_wen_cycles", 64'(wen_count), 64'(1));
    access(1, 1'b0, 3'b010, 32'h20, 32'd0, rd, er);
    chk("lw_20", 64'(rd), 64'h000000000000ABCD);

    // illegal code store
    wen_count = 0;
    access(1, 1'b1, 3'b011, 32'h30, 32'hFFFFFFFF, rd, er);
    chk("ill_err", 64'(er), 64'(1));
    chk("ill_rdata", 64'(rd), 64'(0));
    chk("ill_wen_cycles", 64'(wen_count), 64'(0));
    access(1, 1'b0, 3'b010, 32'h30, 32'd0, rd, er);
    chk("lw_30_unchanged", 64'(rd), 64'h00000000CAFEF00D);

    // contention: both ports continuously requesting
    grant_log.delete();
    fork
      begin
        int l;
        issue(0, 1'b0, 3'b000, 32'h40, 32'd0, l);
        issue(0, 1'b0, 3'b101, 32'h44, 32'd0, l);
        issue(0, 1'b0, 3'b010, 32'h10, 32'd0, l);
        issue(0, 1'b0, 3'b110, 32'h10, 32'd0, l);
      end
      begin
        int l;
        issue(1, 1'b1, 3'b010, 32'h50, 32'hA5A51234, l);
        issue(1, 1'b0, 3'b010, 32'h50, 32'd0, l);
        issue(1, 1'b1, 3'b000, 32'h51, 32'h000000FF, l);
        issue(1, 1'b0, 3'b101, 32'h50, 32'd0, l);
      end
    join
    repeat (4) @(negedge clk);
    chk("contention_grants", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < grant_log.size(); i++) chk("contention_order", 64'(grant_log[i]), 64'(i % 2));

    // reset during WAIT of a port-1 load
    begin
      int l;
      issue(1, 1'b0, 3'b010, 32'h10, 32'd0, l);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    chk("reset_no_rvalid", 64'(p1_rvalid), 64'(0));
    rst_n = 1'b1;
    grant_log.delete();
    fork
      begin int l; issue(0, 1'b0, 3'b010, 32'h10, 32'd0, l); end
      begin int l; issue(1, 1'b0, 3'b010, 32'h30, 32'd0, l); end
    join
    repeat (4) @(negedge clk);
    chk("post_reset_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 0) chk("post_reset_first", 64'(grant_log[0]), 64'(0));

    // reset after a port-0 grant still restores port-0 priority
    access(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    fork
      begin int l; issue(0, 1'b0, 3'b000, 32'h40, 32'd0, l); end
      begin int l; issue(1, 1'b0, 3'b001, 32'h44, 32'd0, l); end
    join
    repeat (4) @(negedge clk);
    chk("reset_last_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 0) chk("reset_last_first", 64'(grant_log[0]), 64'(0));

    chk("q0_drained", 64'(exp_q0.size()), 64'(0));
    chk("q1_drained", 64'(exp_q1.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
